// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state, opcode and select encodings for the ALU control unit
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        WB_ALU,
        ADDR,
        MEM_RD,
        WB_MEM,
        MEM_WR,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    localparam logic [1:0] B_REG_B    = 2'd0;
    localparam logic [1:0] B_IMM      = 2'd1;
    localparam logic [1:0] B_STEP     = 2'd2;
    localparam logic [1:0] B_IMM_SHL1 = 2'd3;

    localparam logic [1:0] PC_SRC_ALU  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'hA) && (op <= 4'hE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts cycles spent waiting on mem_ready, flags the last allowed one
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic clear,
    output logic expire
);

    localparam int W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam int LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    // count holds the number of earlier wait cycles, so LIMIT marks the final one
    assign expire = (MEM_TIMEOUT != 0) && (count == W'(LIMIT));

endmodule

// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - multi-cycle fetch/decode/execute/memory/writeback control unit
import alu_ctrl_pkg::*;

module alu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int PC_STEP     = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       isZero,
    input  logic       ovfl,
    output logic       alu_src,
    output logic [1:0] alu_b_sel,
    output logic [3:0] alu_op,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       wb_sel,
    output logic       halted,
    output logic       ovfl_trap,
    output logic       illegal,
    output logic       mem_fault
);

    if (PC_STEP <= 0) begin : g_bad_pc_step
        $error("alu_ctrl_fsm: PC_STEP must be positive");
    end

    state_t state, state_nxt;
    logic   ovfl_q;
    logic   waiting, expire, fault;

    assign waiting = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign fault   = waiting && !mem_ready && expire;

    // Any non-waiting cycle, completion or abort leaves the counter at zero for the next wait
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (CLK),
        .clear  (reset || !waiting || mem_ready || fault),
        .expire (expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (mem_ready) state_nxt = DECODE;
                    else if (fault) state_nxt = FETCH;
            DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_nxt = EXEC_R;
                    OP_ADDI:                       state_nxt = EXEC_I;
                    OP_LW, OP_SW:                  state_nxt = ADDR;
                    OP_BEQ, OP_BNE:                state_nxt = BRANCH;
                    OP_JMP:                        state_nxt = JUMP;
                    OP_HALT:                       state_nxt = HALT;
                    default:                       state_nxt = FETCH;
                endcase
            end
            EXEC_R, EXEC_I: state_nxt = WB_ALU;
            ADDR:   state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD: if (mem_ready) state_nxt = WB_MEM;
                    else if (fault) state_nxt = FETCH;
            MEM_WR: if (mem_ready || fault) state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= FETCH;
            ovfl_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // logical ops never overflow, so only ADD/SUB (opcode[1]==0) keep the flag
            if (state == EXEC_R) begin
                ovfl_q <= ovfl && !opcode[1];
            end else if (state == EXEC_I) begin
                ovfl_q <= ovfl;
            end
        end
    end

    always_comb begin
        alu_src   = 1'b0;
        alu_b_sel = B_REG_B;
        alu_op    = ALU_ADD;
        pc_write  = 1'b0;
        pc_src    = PC_SRC_ALU;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        halted    = 1'b0;
        ovfl_trap = 1'b0;
        illegal   = 1'b0;
        mem_fault = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    alu_b_sel = B_STEP;
                    mem_read  = !fault;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    mem_fault = fault;
                end
                DECODE: begin
                    alu_b_sel = B_IMM_SHL1;
                    illegal   = is_illegal(opcode);
                end
                EXEC_R, EXEC_I, WB_ALU: begin
                    alu_src = 1'b1;
                    if (opcode == OP_ADDI) begin
                        alu_b_sel = B_IMM;
                    end else begin
                        alu_op = {2'b00, opcode[1:0]};
                    end
                    if (state == WB_ALU) begin
                        reg_write = !ovfl_q;
                        ovfl_trap = ovfl_q;
                    end
                end
                ADDR, MEM_RD, MEM_WR: begin
                    alu_src   = 1'b1;
                    alu_b_sel = B_IMM;
                    mem_read  = (state == MEM_RD) && !fault;
                    mem_write = (state == MEM_WR) && !fault;
                    mem_fault = fault;
                end
                WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = 1'b1;
                end
                BRANCH: begin
                    alu_src  = 1'b1;
                    alu_op   = ALU_SUB;
                    pc_src   = PC_SRC_BR;
                    pc_write = (opcode == OP_BEQ) ? isZero : !isZero;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                end
                HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control unit and initiator side of the ALU system interface.
- Sequences each 16-bit instruction through fetch/decode/execute/memory/writeback.
- Drives ALU operand select, ALU opcode and B-operand select, and consumes the ALU's zero and overflow flags.
- Also drives PC, IR, register-file and memory strobes; handshakes with memory via mem_ready.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting on mem_ready before abort; 0 disables the timeout.
- PC_STEP, 2: byte increment added to PC in FETCH (presented on B via alu_b_sel=STEP).

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  4  inst[15:12] from IR; valid from DECODE onward.
- mem_ready  in  1  memory completed current read/write this cycle.
- isZero  in  1  ALU zero flag (combinational, same cycle).
- ovfl  in  1  ALU signed overflow flag (same cycle).
- alu_src  out  1  0=PC, 1=register A onto ALU A input.
- alu_b_sel  out  2  0=REG_B, 1=IMM, 2=STEP, 3=IMM_SHL1.
- alu_op  out  4  ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3.
- pc_write  out  1  load PC this cycle.
- pc_src  out  2  0=ALU result R, 1=br register, 2=jump target.
- ir_write  out  1  load IR.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register-file write.
- wb_sel  out  1  0=ALU result, 1=memory data.
- halted  out  1  high in HALT.
- ovfl_trap  out  1  one-cycle pulse: arithmetic write suppressed.
- illegal  out  1  one-cycle pulse: undefined opcode.
- mem_fault  out  1  one-cycle pulse: mem_ready timeout.

Behaviour:
- Clock/reset: one clock (CLK). reset is synchronous, active-high. While reset is high, all strobes and pulses are 0. The cycle after reset deasserts, the FSM is in FETCH.
- Outputs: decoded combinationally from state (Moore), plus mem_ready gating where noted. Defaults are 0 except alu_op=ADD.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 JMP, F HALT. Opcodes A-E are illegal.
- FETCH: mem_read=1, alu_src=0, alu_b_sel=STEP, ADD. ir_write and pc_write (pc_src=0) assert only in the cycle mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE (1 cycle): alu_src=0, alu_b_sel=IMM_SHL1, ADD, so the branch target is captured in br. Next state by opcode: 0-3 EXEC_R; 4 EXEC_I; 5/6 ADDR; 7/8 BRANCH; 9 JUMP; F HALT; illegal: pulse illegal, go to FETCH.
- EXEC_R: alu_src=1, b_sel=REG_B, alu_op=opcode[1:0]. EXEC_I: alu_src=1, b_sel=IMM, ADD.
  - Both latch ovfl into ovfl_q (only ADD/SUB/ADDI capture ovfl; AND/OR clear ovfl_q), then go to WB_ALU.
  - ALU operands are held stable into WB_ALU.
- WB_ALU: reg_write=!ovfl_q, wb_sel=0. If ovfl_q, pulse ovfl_trap. Go to FETCH.
- ADDR: alu_src=1, b_sel=IMM, ADD. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: mem_read=1, hold address ALU controls. On mem_ready go to WB_MEM.
- WB_MEM: reg_write=1, wb_sel=1, then FETCH.
- MEM_WR: mem_write=1, hold address. On mem_ready go to FETCH.
- BRANCH: alu_src=1, b_sel=REG_B, SUB. Taken = isZero (BEQ) or !isZero (BNE). pc_write=taken, pc_src=1. Go to FETCH.
- JUMP: pc_write=1, pc_src=2, then FETCH.
- HALT: halted=1, no strobes. Exit only via reset.
- Timeout counter:
  - Clears on entry to FETCH/MEM_RD/MEM_WR and counts each waiting cycle.
  - If it reaches MEM_TIMEOUT with mem_ready still low: drop the request, pulse mem_fault, go to FETCH with no PC/IR/reg write.
  - mem_ready in the same cycle as expiry wins (normal completion).
- Reset mid-operation (including a pending memory wait): the next state is FETCH, no write strobe is issued, and the counter and ovfl_q clear.

Decomposition:
- Package alu_ctrl_pkg:
  - state enum (FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT);
  - opcode constants;
  - ALU_ADD/SUB/AND/OR;
  - B_SEL and PC_SRC constants.
- One sub-module: mem_wait_timer (counter, clear, expire flag), parameterised by MEM_TIMEOUT.

Test Plan:
- Reset then opcode=0 (ADD), mem_ready=1 in FETCH, ovfl=0 -> FETCH, DECODE, EXEC_R (alu_op=0, alu_src=1), WB_ALU (reg_write=1); 4 cycles total.
- opcode=1 (SUB) with ovfl=1 in EXEC_R -> WB_ALU has reg_write=0 and a single-cycle ovfl_trap=1.
- opcode=7 (BEQ), isZero=1 -> BRANCH has pc_write=1, pc_src=1; same with isZero=0 -> pc_write=0; opcode=8 (BNE) gives the inverse.
- opcode=5 (LW), mem_ready low 3 cycles in MEM_RD then high -> mem_read held 4 cycles, then WB_MEM with reg_write=1, wb_sel=1.
- MEM_TIMEOUT=15, mem_ready held low in FETCH -> mem_fault pulses at the 15th wait cycle, no ir_write; opcode=0xB -> illegal pulse, return to FETCH.
- opcode=F -> halted=1 stays high for 20 cycles with no strobes; reset asserted during MEM_WR wait -> mem_write=0 during reset, FETCH next cycle.
